// File: rtl/decode_stage.sv
// RV32I decode stage: DEPTH-entry fetch queue feeding a registered decoder with valid/ready output.
// Optional macro RV32M_EN adds the muldiv output and legalises OP encodings with funct7=0000001.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] immediate,
    output logic [1:0]      op1_src,
    output logic            op2_src,
    output logic [2:0]      alu_op,
    output logic            sign,
    output logic            branch,
    output logic            branch_if_zero,
    output logic            jump,
    output logic            rf_write_en,
    output logic            mem_read_en,
    output logic            mem_write_en,
`ifdef RV32M_EN
    output logic            muldiv,
`endif
    output logic            illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [1:0]      op1;
        logic            op2;
        logic [2:0]      alu;
        logic            sign;
        logic            branch;
        logic            bz;
        logic            jump;
        logic            rf_we;
        logic            mem_re;
        logic            mem_we;
        logic            illegal;
`ifdef RV32M_EN
        logic            muldiv;
`endif
    } dec_t;

    logic [XLEN-1:0] r_q_pc  [DEPTH];
    logic [31:0]     r_q_ins [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            r_out_valid;
    logic [XLEN-1:0] r_pc;
    dec_t            r_dec;

    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_ins;
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [31:0]     w_imm_i;
    logic [31:0]     w_imm_s;
    logic [31:0]     w_imm_b;
    logic [31:0]     w_imm_u;
    logic [31:0]     w_imm_j;
    logic            w_legal;
    dec_t            w_dec;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    assign in_ready = (r_count != CW'(DEPTH));
    assign w_push   = in_valid && in_ready;
    // Head moves to the output register whenever that register is free or being drained.
    assign w_pop    = (r_count != '0) && (!r_out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_q_pc[r_wr_ptr]  <= in_pc;
            r_q_ins[r_wr_ptr] <= in_instruction;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_ins   = r_q_ins[r_rd_ptr];
    assign w_opc   = w_ins[6:0];
    assign w_f3    = w_ins[14:12];
    assign w_f7    = w_ins[31:25];
    assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
    assign w_imm_s = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
    assign w_imm_b = {{20{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
    assign w_imm_u = {w_ins[31:12], 12'b0};
    assign w_imm_j = {{12{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

    always_comb begin
        w_dec   = '0;
        w_legal = 1'b1;
        case (w_opc)
            OPC_OP: begin
                w_dec.rs1   = w_ins[19:15];
                w_dec.rs2   = w_ins[24:20];
                w_dec.rd    = w_ins[11:7];
                w_dec.alu   = w_f3;
                w_dec.rf_we = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    w_dec.sign = 1'b0;
                end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
                    w_dec.sign = 1'b1;
`ifdef RV32M_EN
                end else if (w_f7 == 7'b0000001) begin
                    w_dec.muldiv = 1'b1;
`endif
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                w_dec.rs1   = w_ins[19:15];
                w_dec.rd    = w_ins[11:7];
                w_dec.imm   = sext(w_imm_i);
                w_dec.op2   = 1'b1;
                w_dec.alu   = w_f3;
                w_dec.rf_we = 1'b1;
                // Only the shift forms constrain funct7; SRAI is the sole user of sign.
                if (w_f3 == 3'b001) begin
                    w_legal = (w_f7 == 7'b0000000);
                end else if (w_f3 == 3'b101) begin
                    w_legal    = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    w_dec.sign = w_f7[5];
                end
            end
            OPC_LUI: begin
                w_dec.rd    = w_ins[11:7];
                w_dec.imm   = sext(w_imm_u);
                w_dec.op1   = 2'b10;
                w_dec.op2   = 1'b1;
                w_dec.rf_we = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.rd    = w_ins[11:7];
                w_dec.imm   = sext(w_imm_u);
                w_dec.op1   = 2'b01;
                w_dec.op2   = 1'b1;
                w_dec.rf_we = 1'b1;
            end
            OPC_JAL: begin
                w_dec.rd    = w_ins[11:7];
                w_dec.imm   = sext(w_imm_j);
                w_dec.op1   = 2'b01;
                w_dec.op2   = 1'b1;
                w_dec.jump  = 1'b1;
                w_dec.rf_we = 1'b1;
            end
            OPC_JALR: begin
                w_dec.rs1   = w_ins[19:15];
                w_dec.rd    = w_ins[11:7];
                w_dec.imm   = sext(w_imm_i);
                w_dec.op2   = 1'b1;
                w_dec.jump  = 1'b1;
                w_dec.rf_we = 1'b1;
                w_legal     = (w_f3 == 3'b000);
            end
            OPC_BRANCH: begin
                w_dec.rs1    = w_ins[19:15];
                w_dec.rs2    = w_ins[24:20];
                w_dec.imm    = sext(w_imm_b);
                w_dec.branch = 1'b1;
                case (w_f3)
                    3'b000: begin w_dec.alu = 3'b000; w_dec.sign = 1'b1; w_dec.bz = 1'b1; end
                    3'b001: begin w_dec.alu = 3'b000; w_dec.sign = 1'b1; end
                    3'b100: w_dec.alu = 3'b010;
                    3'b101: begin w_dec.alu = 3'b010; w_dec.bz = 1'b1; end
                    3'b110: w_dec.alu = 3'b011;
                    3'b111: begin w_dec.alu = 3'b011; w_dec.bz = 1'b1; end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                w_dec.rs1    = w_ins[19:15];
                w_dec.rd     = w_ins[11:7];
                w_dec.imm    = sext(w_imm_i);
                w_dec.op2    = 1'b1;
                w_dec.mem_re = 1'b1;
                w_dec.rf_we  = 1'b1;
                w_legal      = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
            end
            OPC_STORE: begin
                w_dec.rs1    = w_ins[19:15];
                w_dec.rs2    = w_ins[24:20];
                w_dec.imm    = sext(w_imm_s);
                w_dec.op2    = 1'b1;
                w_dec.mem_we = 1'b1;
                w_legal      = (w_f3[2] == 1'b0) && (w_f3 != 3'b011);
            end
            OPC_FENCE: begin
                w_legal = 1'b1;
            end
            OPC_SYSTEM: begin
                // ECALL and EBREAK only; CSR accesses are not part of this core.
                w_legal = (w_ins[31:7] == 25'h0) || (w_ins[31:7] == 25'h2000);
            end
            default: w_legal = 1'b0;
        endcase

        if (!w_legal) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end
        if (w_dec.rd == 5'd0) w_dec.rf_we = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_dec       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_pc        <= r_q_pc[r_rd_ptr];
            r_dec       <= w_dec;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign pc             = r_pc;
    assign rs1            = r_dec.rs1;
    assign rs2            = r_dec.rs2;
    assign rd             = r_dec.rd;
    assign immediate      = r_dec.imm;
    assign op1_src        = r_dec.op1;
    assign op2_src        = r_dec.op2;
    assign alu_op         = r_dec.alu;
    assign sign           = r_dec.sign;
    assign branch         = r_dec.branch;
    assign branch_if_zero = r_dec.bz;
    assign jump           = r_dec.jump;
    assign rf_write_en    = r_dec.rf_we;
    assign mem_read_en    = r_dec.mem_re;
    assign mem_write_en   = r_dec.mem_we;
    assign illegal        = r_dec.illegal;
`ifdef RV32M_EN
    assign muldiv         = r_dec.muldiv;
`endif

endmodule
